// File: rtl/mem_io_responder_if.sv
// Byte-serial memory bus between the memory controller (master) and its target (slave).
// The controller drives address, write data and direction; the target returns read data and backpressure.
interface mem_io_responder_if;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic [7:0]  mem_din;
  logic        io_buffer_full;

  modport master (
    output mem_a, mem_dout, mem_wr,
    input  mem_din, io_buffer_full
  );

  modport slave (
    input  mem_a, mem_dout, mem_wr,
    output mem_din, io_buffer_full
  );
endinterface

// File: rtl/mem_io_responder.sv
// Bus target: byte RAM plus a small memory-mapped IO window (UART TX/RX FIFOs, status, halt).
// Read data returns one cycle after the read; io_buffer_full leaves headroom for a write in flight.
module mem_io_responder #(
  parameter int ADDR_WIDTH  = 17,
  parameter int FIFO_DEPTH  = 8,
  parameter int FULL_MARGIN = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  mem_io_responder_if.slave    bus,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic                 rx_overflow,
  output logic                 tx_overflow,
  output logic                 halt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [17:0]      IO_DATA  = 18'h30000;
  localparam logic [17:0]      IO_STAT  = 18'h30004;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] MARGIN_C = CNT_W'(FULL_MARGIN);

  // ---------------- address decode ----------------
  logic [17:0]           addr;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  io_sel, hit_data, hit_stat;
  logic                  bus_rd, bus_wr;
  logic                  unused_addr_bits;

  assign addr             = bus.mem_a[17:0];
  assign ram_addr         = bus.mem_a[ADDR_WIDTH-1:0];
  assign unused_addr_bits = ^bus.mem_a[31:18];
  assign io_sel           = (addr[17:16] == 2'b11);
  assign hit_data         = (addr == IO_DATA);
  assign hit_stat         = (addr == IO_STAT);
  assign bus_rd           = rdy && !bus.mem_wr;
  assign bus_wr           = rdy &&  bus.mem_wr;

  // ---------------- TX FIFO (bus writes in, consumer pops) ----------------
  logic [7:0]       tx_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] tx_wr_ptr, tx_rd_ptr;
  logic [CNT_W-1:0] tx_count;
  logic             tx_full, tx_pop, tx_push_req, tx_push;

  assign tx_full     = (tx_count == DEPTH_C);
  assign tx_valid    = (tx_count != '0);
  assign tx_data     = tx_mem[tx_rd_ptr];
  assign tx_pop      = rdy && tx_valid && tx_ready;
  assign tx_push_req = bus_wr && hit_data;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign tx_push     = tx_push_req && (!tx_full || tx_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wr_ptr   <= '0;
      tx_rd_ptr   <= '0;
      tx_count    <= '0;
      tx_overflow <= 1'b0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
      tx_count <= tx_count + CNT_W'(tx_push) - CNT_W'(tx_pop);
      if (tx_push_req && !tx_push) tx_overflow <= 1'b1;
    end
  end

  // NOTE: storage arrays carry no reset; validity is tracked by the reset pointers/counts.
  always_ff @(posedge clk) begin
    if (!rst && tx_push) tx_mem[tx_wr_ptr] <= bus.mem_dout;
  end

  assign bus.io_buffer_full = ((DEPTH_C - tx_count) <= MARGIN_C);

  // ---------------- RX FIFO (rx port pushes, bus reads pop) ----------------
  logic [7:0]       rx_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rx_wr_ptr, rx_rd_ptr;
  logic [CNT_W-1:0] rx_count;
  logic             rx_full, rx_nonempty, rx_pop, rx_push_req, rx_push;

  assign rx_full     = (rx_count == DEPTH_C);
  assign rx_nonempty = (rx_count != '0);
  assign rx_pop      = bus_rd && hit_data && rx_nonempty;
  assign rx_push_req = rdy && rx_valid;
  assign rx_push     = rx_push_req && (!rx_full || rx_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wr_ptr   <= '0;
      rx_rd_ptr   <= '0;
      rx_count    <= '0;
      rx_overflow <= 1'b0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
      rx_count <= rx_count + CNT_W'(rx_push) - CNT_W'(rx_pop);
      if (rx_push_req && !rx_push) rx_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && rx_push) rx_mem[rx_wr_ptr] <= rx_data;
  end

  // ---------------- halt register ----------------
  always_ff @(posedge clk) begin
    if (rst)                     halt <= 1'b0;
    else if (bus_wr && hit_stat) halt <= 1'b1;
  end

  // ---------------- read path ----------------
  logic [7:0] io_rd_data;

  always_comb begin
    io_rd_data = 8'h00;
    if (hit_data && rx_nonempty) io_rd_data = rx_mem[rx_rd_ptr];
    else if (hit_stat)           io_rd_data = {6'b0, rx_nonempty, bus.io_buffer_full};
  end

  // RAM and IO read data are registered separately so the RAM keeps a plain
  // synchronous-read shape; src_ram selects which one the last read targeted.
  logic [7:0] ram [2**ADDR_WIDTH];
  logic [7:0] ram_q, io_q;
  logic       src_ram;

  always_ff @(posedge clk) begin
    if (!rst && bus_wr && !io_sel) ram[ram_addr] <= bus.mem_dout;
    if (!rst && bus_rd)            ram_q         <= ram[ram_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      io_q    <= 8'h00;
      src_ram <= 1'b0;
    end else if (bus_rd) begin
      io_q    <= io_rd_data;
      src_ram <= !io_sel;
    end
  end

  assign bus.mem_din = src_ram ? ram_q : io_q;

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: RAM access/aliasing, TX/RX FIFO rules, status, halt, rdy and reset.
module tb_mem_io_responder;

  logic       clk = 1'b0;
  logic       rst, rdy;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, rx_overflow, tx_overflow, halt;
  int         checks = 0;
  int         errors = 0;

  mem_io_responder_if bus ();

  mem_io_responder dut (
    .clk         (clk),
    .rst         (rst),
    .rdy         (rdy),
    .bus         (bus.slave),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_overflow (rx_overflow),
    .tx_overflow (tx_overflow),
    .halt        (halt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Idle bus: read of an unmapped IO address, no side effects, returns 0x00.
  task automatic park();
    bus.mem_a  = 32'h0003_0008;
    bus.mem_wr = 1'b0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [7:0] d);
    bus.mem_a    = a;
    bus.mem_dout = d;
    bus.mem_wr   = 1'b1;
    step();
    park();
  endtask

  task automatic bus_read(input logic [31:0] a, input logic [7:0] exp, input string tag);
    bus.mem_a  = a;
    bus.mem_wr = 1'b0;
    step();
    check(tag, bus.mem_din, exp);
    park();
  endtask

  task automatic rx_push(input logic [7:0] d);
    rx_data  = d;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    bus.mem_dout = 8'h00;
    park();
    step(); step();
    rst = 1'b0;

    check("reset_mem_din", bus.mem_din, 8'h00);
    check("reset_tx_valid", {7'b0, tx_valid}, 8'h00);
    check("reset_io_full", {7'b0, bus.io_buffer_full}, 8'h00);
    check("reset_halt", {7'b0, halt}, 8'h00);
    check("reset_tx_ovf", {7'b0, tx_overflow}, 8'h00);
    check("reset_rx_ovf", {7'b0, rx_overflow}, 8'h00);

    // RAM write, then a read whose data appears exactly one cycle later
    bus_read(32'h0003_0008, 8'h00, "t1_io_unmapped");
    bus_write(32'h0000_0123, 8'hA5);
    check("t1_hold_on_write", bus.mem_din, 8'h00);
    bus.mem_a = 32'h0000_0123; bus.mem_wr = 1'b0;
    #1 check("t1_not_early", bus.mem_din, 8'h00);
    step();
    check("t1_read", bus.mem_din, 8'hA5);
    park();

    // Aliasing above ADDR_WIDTH, unmapped IO read
    bus_write(32'h0002_0010, 8'h3C);
    bus_read(32'h0000_0010, 8'h3C, "t2_alias");
    bus_read(32'h0003_0008, 8'h00, "t2_io_other");

    // TX fill with no consumer
    for (int i = 1; i <= 6; i++) begin
      bus_write(32'h0003_0000, 8'(i));
      if (i == 5) check("t3_not_full_5", {7'b0, bus.io_buffer_full}, 8'h00);
    end
    check("t3_full_6", {7'b0, bus.io_buffer_full}, 8'h01);
    check("t3_tx_head", tx_data, 8'h01);
    bus_write(32'h0003_0000, 8'h07);
    bus_write(32'h0003_0000, 8'h08);
    check("t3_no_ovf_8", {7'b0, tx_overflow}, 8'h00);
    bus_read(32'h0003_0004, 8'h01, "t3_status");
    bus_write(32'h0003_0000, 8'h09);
    check("t3_ovf_9", {7'b0, tx_overflow}, 8'h01);
    tx_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      check("t3_drain_valid", {7'b0, tx_valid}, 8'h01);
      check("t3_drain_data", tx_data, 8'(i));
      step();
    end
    tx_ready = 1'b0;
    check("t3_drained", {7'b0, tx_valid}, 8'h00);
    check("t3_full_clear", {7'b0, bus.io_buffer_full}, 8'h00);

    // Push into a full TX FIFO while its head is popped
    for (int i = 0; i < 8; i++) bus_write(32'h0003_0000, 8'(8'h10 + i));
    tx_ready = 1'b1;
    bus_write(32'h0003_0000, 8'h18);
    tx_ready = 1'b0;
    check("t4_still_full", {7'b0, bus.io_buffer_full}, 8'h01);
    check("t4_head", tx_data, 8'h11);
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("t4_drain_data", tx_data, 8'(8'h11 + i));
      step();
    end
    tx_ready = 1'b0;
    check("t4_drained", {7'b0, tx_valid}, 8'h00);

    // RX FIFO via status and data registers
    rx_push(8'h41);
    rx_push(8'h42);
    bus_read(32'h0003_0004, 8'h02, "t5_status_a");
    bus_read(32'h0003_0004, 8'h02, "t5_status_b");
    bus_read(32'h0003_0000, 8'h41, "t5_pop_41");
    bus_read(32'h0003_0000, 8'h42, "t5_pop_42");
    bus_read(32'h0003_0000, 8'h00, "t5_pop_empty");
    bus_read(32'h0003_0004, 8'h00, "t5_status_empty");
    rx_push(8'h51);
    rx_push(8'h52);
    bus_read(32'h0003_0000, 8'h51, "t5_word_b0");
    bus_read(32'h0003_0001, 8'h00, "t5_word_b1");
    bus_read(32'h0003_0002, 8'h00, "t5_word_b2");
    bus_read(32'h0003_0003, 8'h00, "t5_word_b3");
    bus_read(32'h0003_0000, 8'h52, "t5_single_pop");
    for (int i = 0; i < 9; i++) rx_push(8'(8'h60 + i));
    check("t5_rx_ovf", {7'b0, rx_overflow}, 8'h01);
    bus_read(32'h0003_0000, 8'h60, "t5_rx_head_after_ovf");

    // rdy=0 freezes pops and writes
    bus_write(32'h0003_0000, 8'hAB);
    bus_write(32'h0003_0000, 8'hCD);
    rdy = 1'b0; tx_ready = 1'b1;
    step();
    check("t6_rdy_no_pop", tx_data, 8'hAB);
    tx_ready = 1'b0;
    bus_write(32'h0000_0123, 8'hFF);
    rdy = 1'b1;
    bus_read(32'h0000_0123, 8'hA5, "t6_rdy_no_write");
    rdy = 1'b0;
    bus_read(32'h0003_0008, 8'hA5, "t6_rdy_hold_din");
    rdy = 1'b1;

    // Halt, then reset with a discarded bus write
    check("t6_halt_before", {7'b0, halt}, 8'h00);
    bus_write(32'h0003_0004, 8'h00);
    check("t6_halt_set", {7'b0, halt}, 8'h01);
    bus_read(32'h0000_0123, 8'hA5, "t6_pre_reset_read");
    rst = 1'b1;
    bus.mem_a = 32'h0000_0123; bus.mem_dout = 8'h77; bus.mem_wr = 1'b1;
    step();
    rst = 1'b0;
    park();
    check("t6_rst_halt", {7'b0, halt}, 8'h00);
    check("t6_rst_tx_valid", {7'b0, tx_valid}, 8'h00);
    check("t6_rst_io_full", {7'b0, bus.io_buffer_full}, 8'h00);
    check("t6_rst_tx_ovf", {7'b0, tx_overflow}, 8'h00);
    check("t6_rst_rx_ovf", {7'b0, rx_overflow}, 8'h00);
    check("t6_rst_mem_din", bus.mem_din, 8'h00);
    bus_read(32'h0000_0123, 8'hA5, "t6_ram_survives");
    bus_read(32'h0003_0004, 8'h00, "t6_rst_status");
    bus_read(32'h0003_0000, 8'h00, "t6_rst_rx_empty");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
